control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE controller for a 16-bit, 6-bit-address datapath.
// Optional build macro CTRL_TRAP_ILLEGAL_EN: illegal opcodes halt and raise illegal_op.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [5:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [1:0]  alu_op,
  output logic [2:0]  source_sel,
  output logic [5:0]  ins_immediate,
  output logic [5:0]  pc,
  input  logic        negative,
  input  logic        zero,
  input  logic        positive,
  output logic [2:0]  sr1_sel,
  output logic [2:0]  sr2_sel,
  output logic [2:0]  dr_sel,
  output logic        reg_we,
  output logic [2:0]  cc,
  output logic        halted
`ifdef CTRL_TRAP_ILLEGAL_EN
  ,
  output logic        illegal_op
`endif
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_LEA  = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        is_add, is_and, is_not, is_lea, is_br, is_halt, is_alu;
  logic        is_illegal;
  logic        br_taken;
  logic        trap;
  logic [5:0]  pc_next;

  assign opcode     = ir[15:12];
  assign is_add     = (opcode == OP_ADD);
  assign is_and     = (opcode == OP_AND);
  assign is_not     = (opcode == OP_NOT);
  assign is_lea     = (opcode == OP_LEA);
  assign is_br      = (opcode == OP_BR);
  assign is_halt    = (opcode == OP_HALT);
  assign is_alu     = is_add | is_and | is_not | is_lea;
  assign is_illegal = ~(is_alu | is_br | is_halt);

  assign br_taken = (ir[11] & cc[2]) | (ir[10] & cc[1]) | (ir[9] & cc[0]);
  // 6-bit add wraps mod 64, so the two's-complement offset needs no sign extension
  assign pc_next  = (is_br && br_taken) ? (pc + 6'd1 + ir[5:0]) : (pc + 6'd1);

`ifdef CTRL_TRAP_ILLEGAL_EN
  assign trap = is_illegal;
`else
  assign trap = 1'b0;
`endif

  assign imem_addr     = pc;
  assign sr1_sel       = ir[8:6];
  assign sr2_sel       = ir[2:0];
  assign dr_sel        = ir[11:9];
  assign ins_immediate = ir[5:0];
  assign reg_we        = (state == S_EXECUTE) && is_alu;
  assign halted        = (state == S_HALT);

  always_comb begin
    alu_op     = 2'b00;
    source_sel = 3'b000;
    if (is_add || is_and || is_not) begin
      alu_op     = is_and ? 2'b01 : (is_not ? 2'b10 : 2'b00);
      source_sel = ir[5] ? 3'b000 : 3'b010;
    end else if (is_lea) begin
      source_sel = 3'b001;
    end
  end

  // imem_req is registered so it stays low through reset and rises one cycle later;
  // a fetch is only accepted once the request is actually visible on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      cc       <= 3'b010;
      imem_req <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          pc <= pc_next;
          if (is_alu) cc <= {negative, zero, positive};
          if (is_halt || trap) begin
            imem_req <= 1'b0;
            state    <= S_HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_HALT;
        end
      endcase
    end
  end

`ifdef CTRL_TRAP_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_op <= 1'b0;
    else if (state == S_EXECUTE && is_illegal) illegal_op <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; follows CTRL_TRAP_ILLEGAL_EN when defined.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [1:0]  alu_op;
  logic [2:0]  source_sel;
  logic [5:0]  ins_immediate;
  logic [5:0]  pc;
  logic        negative, zero, positive;
  logic [2:0]  sr1_sel, sr2_sel, dr_sel;
  logic        reg_we;
  logic [2:0]  cc;
  logic        halted;
`ifdef CTRL_TRAP_ILLEGAL_EN
  logic        illegal_op;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [5:0]  exp_pc;

  control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .alu_op(alu_op), .source_sel(source_sel), .ins_immediate(ins_immediate), .pc(pc),
    .negative(negative), .zero(zero), .positive(positive),
    .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .dr_sel(dr_sel), .reg_we(reg_we),
    .cc(cc), .halted(halted)
`ifdef CTRL_TRAP_ILLEGAL_EN
    , .illegal_op(illegal_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_flags(input logic n, input logic z, input logic p);
    negative = n; zero = z; positive = p;
  endtask

  // Presents one instruction on the fetch port; returns at the negedge after acceptance (DECODE).
  task automatic fetch(input logic [15:0] instr);
    int unsigned wait_cnt = 0;
    while (imem_req !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (imem_req !== 1'b1) begin
      tests++; fails++;
      $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
    end
    imem_rdata = instr;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  task automatic run(input logic [15:0] instr);
    fetch(instr);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; set_flags(0, 0, 0);
    @(negedge clk); @(negedge clk);
    tests++; if (pc !== 6'd0)       begin fails++; $display("FAIL reset_pc: got %0d required 0", pc); end
    tests++; if (cc !== 3'b010)     begin fails++; $display("FAIL reset_cc: got %b required 010", cc); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b required 0", imem_req); end
    tests++; if (halted !== 1'b0)   begin fails++; $display("FAIL reset_halted: got %b required 0", halted); end
    tests++; if (reg_we !== 1'b0)   begin fails++; $display("FAIL reset_we: got %b required 0", reg_we); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b required 1", imem_req); end
    tests++; if (imem_addr !== 6'd0) begin fails++; $display("FAIL first_addr: got %0d required 0", imem_addr); end
  endtask

  task automatic test_branch_jump;
    fetch(16'h4E04);
    @(negedge clk);
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL br_we: got %b required 0", reg_we); end
    @(negedge clk);
    tests++; if (pc !== 6'd5) begin fails++; $display("FAIL br_jump_pc: got %0d required 5", pc); end
  endtask

  task automatic test_add_imm;
    set_flags(0, 0, 1);
    fetch(16'h0274);
    tests++; if (alu_op !== 2'b00)      begin fails++; $display("FAIL add_aluop: got %b required 00", alu_op); end
    tests++; if (source_sel !== 3'b000) begin fails++; $display("FAIL add_src: got %b required 000", source_sel); end
    tests++; if (ins_immediate !== 6'h34) begin fails++; $display("FAIL add_imm: got %h required 34", ins_immediate); end
    tests++; if (dr_sel !== 3'd1)  begin fails++; $display("FAIL add_dr: got %0d required 1", dr_sel); end
    tests++; if (sr1_sel !== 3'd1) begin fails++; $display("FAIL add_sr1: got %0d required 1", sr1_sel); end
    tests++; if (sr2_sel !== 3'd4) begin fails++; $display("FAIL add_sr2: got %0d required 4", sr2_sel); end
    tests++; if (reg_we !== 1'b0)  begin fails++; $display("FAIL add_we_decode: got %b required 0", reg_we); end
    @(negedge clk);
    tests++; if (reg_we !== 1'b1) begin fails++; $display("FAIL add_we_exec: got %b required 1", reg_we); end
    tests++; if (pc !== 6'd5)     begin fails++; $display("FAIL add_pc_exec: got %0d required 5", pc); end
    @(negedge clk);
    tests++; if (reg_we !== 1'b0)   begin fails++; $display("FAIL add_we_after: got %b required 0", reg_we); end
    tests++; if (pc !== 6'd6)       begin fails++; $display("FAIL add_pc_next: got %0d required 6", pc); end
    tests++; if (cc !== 3'b001)     begin fails++; $display("FAIL add_cc: got %b required 001", cc); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL add_next_req: got %b required 1", imem_req); end
  endtask

  task automatic test_branch_cc;
    run(16'h4E03);
    tests++; if (pc !== 6'd10) begin fails++; $display("FAIL br_to10: got %0d required 10", pc); end
    set_flags(1, 0, 0);
    fetch(16'h423E);
    @(negedge clk);
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL br_taken_we: got %b required 0", reg_we); end
    @(negedge clk);
    tests++; if (pc !== 6'd9)   begin fails++; $display("FAIL br_taken_pc: got %0d required 9", pc); end
    tests++; if (cc !== 3'b001) begin fails++; $display("FAIL br_cc_kept: got %b required 001", cc); end
    set_flags(0, 1, 0);
    fetch(16'h0042);
    tests++; if (source_sel !== 3'b010) begin fails++; $display("FAIL addreg_src: got %b required 010", source_sel); end
    tests++; if (sr2_sel !== 3'd2) begin fails++; $display("FAIL addreg_sr2: got %0d required 2", sr2_sel); end
    @(negedge clk); @(negedge clk);
    tests++; if (cc !== 3'b010) begin fails++; $display("FAIL addreg_cc: got %b required 010", cc); end
    run(16'h423E);
    tests++; if (pc !== 6'd11) begin fails++; $display("FAIL br_not_taken_pc: got %0d required 11", pc); end
  endtask

  task automatic test_alu_ops;
    set_flags(1, 0, 0);
    fetch(16'h1021);
    tests++; if (alu_op !== 2'b01)      begin fails++; $display("FAIL and_aluop: got %b required 01", alu_op); end
    tests++; if (source_sel !== 3'b000) begin fails++; $display("FAIL and_src: got %b required 000", source_sel); end
    @(negedge clk); @(negedge clk);
    tests++; if (cc !== 3'b100) begin fails++; $display("FAIL and_cc: got %b required 100", cc); end
    tests++; if (pc !== 6'd12)  begin fails++; $display("FAIL and_pc: got %0d required 12", pc); end
    set_flags(0, 0, 1);
    fetch(16'h2000);
    tests++; if (alu_op !== 2'b10)      begin fails++; $display("FAIL not_aluop: got %b required 10", alu_op); end
    tests++; if (source_sel !== 3'b010) begin fails++; $display("FAIL not_src: got %b required 010", source_sel); end
    @(negedge clk);
    tests++; if (reg_we !== 1'b1) begin fails++; $display("FAIL not_we: got %b required 1", reg_we); end
    @(negedge clk);
    tests++; if (pc !== 6'd13) begin fails++; $display("FAIL not_pc: got %0d required 13", pc); end
  endtask

  task automatic test_lea;
    run(16'h4E0E);
    tests++; if (pc !== 6'd28) begin fails++; $display("FAIL lea_jump: got %0d required 28", pc); end
    set_flags(0, 1, 0);
    fetch(16'h3014);
    @(negedge clk);
    tests++; if (alu_op !== 2'b00)      begin fails++; $display("FAIL lea_aluop: got %b required 00", alu_op); end
    tests++; if (source_sel !== 3'b001) begin fails++; $display("FAIL lea_src: got %b required 001", source_sel); end
    tests++; if (pc !== 6'd28)          begin fails++; $display("FAIL lea_pc_exec: got %0d required 28", pc); end
    tests++; if (reg_we !== 1'b1)       begin fails++; $display("FAIL lea_we: got %b required 1", reg_we); end
    @(negedge clk);
    tests++; if (pc !== 6'd29)  begin fails++; $display("FAIL lea_pc_next: got %0d required 29", pc); end
    tests++; if (cc !== 3'b010) begin fails++; $display("FAIL lea_cc: got %b required 010", cc); end
  endtask

  task automatic test_fetch_wait;
    for (int i = 0; i < 4; i++) begin
      tests++; if (imem_req !== 1'b1)   begin fails++; $display("FAIL wait_req[%0d]: got %b required 1", i, imem_req); end
      tests++; if (imem_addr !== 6'd29) begin fails++; $display("FAIL wait_addr[%0d]: got %0d required 29", i, imem_addr); end
      tests++; if (reg_we !== 1'b0)     begin fails++; $display("FAIL wait_we[%0d]: got %b required 0", i, reg_we); end
      @(negedge clk);
    end
    run(16'h4005);
    tests++; if (pc !== 6'd30) begin fails++; $display("FAIL br_nop_pc: got %0d required 30", pc); end
  endtask

  task automatic test_wrap;
    run(16'h4E3F);
    tests++; if (pc !== 6'd30) begin fails++; $display("FAIL self_loop_pc: got %0d required 30", pc); end
    run(16'h4E1F);
    tests++; if (pc !== 6'd62) begin fails++; $display("FAIL jump62_pc: got %0d required 62", pc); end
    set_flags(0, 0, 1);
    run(16'h0274);
    run(16'h0274);
    tests++; if (pc !== 6'd0) begin fails++; $display("FAIL wrap_pc: got %0d required 0", pc); end
  endtask

  task automatic test_illegal;
    set_flags(1, 0, 0);
    fetch(16'h7000);
    @(negedge clk);
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL illegal_we: got %b required 0", reg_we); end
    @(negedge clk);
`ifdef CTRL_TRAP_ILLEGAL_EN
    tests++; if (halted !== 1'b1)     begin fails++; $display("FAIL illegal_halted: got %b required 1", halted); end
    tests++; if (illegal_op !== 1'b1) begin fails++; $display("FAIL illegal_flag: got %b required 1", illegal_op); end
    tests++; if (imem_req !== 1'b0)   begin fails++; $display("FAIL illegal_req: got %b required 0", imem_req); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 6'd0;
`else
    tests++; if (pc !== 6'd1)     begin fails++; $display("FAIL illegal_pc: got %0d required 1", pc); end
    tests++; if (cc !== 3'b001)   begin fails++; $display("FAIL illegal_cc: got %b required 001", cc); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL illegal_halted: got %b required 0", halted); end
    exp_pc = 6'd1;
`endif
  endtask

  task automatic test_halt;
    run(16'hF000);
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag: got %b required 1", halted); end
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 16'h0274; imem_ready = 1'b1;
      @(negedge clk);
      tests++; if (halted !== 1'b1)   begin fails++; $display("FAIL halt_hold[%0d]: got %b required 1", i, halted); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_req[%0d]: got %b required 0", i, imem_req); end
      tests++; if (reg_we !== 1'b0)   begin fails++; $display("FAIL halt_we[%0d]: got %b required 0", i, reg_we); end
      tests++; if (pc !== exp_pc + 6'd1) begin fails++; $display("FAIL halt_pc[%0d]: got %0d required %0d", i, pc, exp_pc + 6'd1); end
    end
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (pc !== 6'd0)     begin fails++; $display("FAIL halt_rst_pc: got %0d required 0", pc); end
    tests++; if (cc !== 3'b010)   begin fails++; $display("FAIL halt_rst_cc: got %b required 010", cc); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_rst_halted: got %b required 0", halted); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL halt_resume_req: got %b required 1", imem_req); end
  endtask

  task automatic test_reset_abort;
    set_flags(1, 0, 0);
    fetch(16'h0274);
    @(negedge clk);
    tests++; if (reg_we !== 1'b1) begin fails++; $display("FAIL abort_we_pre: got %b required 1", reg_we); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (reg_we !== 1'b0)   begin fails++; $display("FAIL abort_we: got %b required 0", reg_we); end
    tests++; if (cc !== 3'b010)     begin fails++; $display("FAIL abort_cc: got %b required 010", cc); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL abort_req: got %b required 0", imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (pc !== 6'd0)       begin fails++; $display("FAIL abort_pc: got %0d required 0", pc); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL abort_resume_req: got %b required 1", imem_req); end
  endtask

  initial begin
    test_reset;
    test_branch_jump;
    test_add_imm;
    test_branch_cc;
    test_alu_ops;
    test_lea;
    test_fetch_wait;
    test_wrap;
    test_illegal;
    test_halt;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
